// File: rtl/fb_if.sv
// fb_if: CPU store path, scan-out read path and swap/clear control of frame_buffer_db.
interface fb_if #(parameter int ADDR_W = 19);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [3:0]        wr_mask;
   logic              rd_en;
   logic [9:0]        x;
   logic [9:0]        y;
   logic              vblank;
   logic              swap_req;
   logic              clear_req;
   logic [7:0]        clear_color;
   logic [7:0]        rd_data;
   logic              rd_valid;
   logic              front_sel;
   logic              swap_pending;
   logic              busy;
   modport master (
      output wr_en, wr_addr, wr_data, wr_mask, rd_en, x, y, vblank, swap_req, clear_req, clear_color,
      input  rd_data, rd_valid, front_sel, swap_pending, busy
   );
   modport slave (
      input  wr_en, wr_addr, wr_data, wr_mask, rd_en, x, y, vblank, swap_req, clear_req, clear_color,
      output rd_data, rd_valid, front_sel, swap_pending, busy
   );
endinterface

// File: rtl/frame_buffer_db.sv
// frame_buffer_db: double-buffered 8bpp frame buffer with vblank-synchronised swap and clear engine.
// Define FB_AUTO_CLEAR_EN to refill the newly exposed back bank after every completed swap.
module frame_buffer_db #(
   parameter int         WIDTH  = 640,
   parameter int         HEIGHT = 480,
   parameter int         ADDR_W = 19,
   parameter logic [7:0] BORDER = 8'hFF
) (
   input logic clk,
   input logic rst,
   fb_if.slave bus
);
   localparam int MEM_SIZE = WIDTH * HEIGHT;
   localparam int AW = $clog2(MEM_SIZE);
   localparam logic [1:0] IDLE = 2'd0, PENDING = 2'd1, CLEAR = 2'd2;
   localparam logic [ADDR_W:0] MEM_END = (ADDR_W+1)'(MEM_SIZE);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_SIZE - 1);
   logic [7:0] mem [2][MEM_SIZE];
   logic [1:0] state_q, state_d;
   logic front_sel_q, front_sel_d, vblank_q, vb_rise;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [7:0] fill_q, fill_d, rd_data_q, rd_data_d;
   logic [ADDR_W:0] idx_d;
   logic [AW-1:0] idx_q;
   logic in_q, in_d, ren_q, bank_q, rd_valid_q;
   logic [ADDR_W:0] lane_full [4];
   logic [AW-1:0] lane_a [4];
   logic [3:0] lane_we;
   // Lanes past the end of the bank are dropped rather than wrapped.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lane_full[i] = {1'b0, bus.wr_addr} + (ADDR_W+1)'(i);
         lane_a[i] = lane_full[i][AW-1:0];
         lane_we[i] = bus.wr_en && state_q != CLEAR && bus.wr_mask[i] && lane_full[i] < MEM_END;
      end
   end
   // Index kept one bit wider than the address so a large x/y can never alias a visible pixel.
   always_comb begin
      idx_d = (ADDR_W+1)'(bus.y) * (ADDR_W+1)'(WIDTH) + (ADDR_W+1)'(bus.x);
      in_d = {1'b0, bus.x} < 11'(WIDTH) && {1'b0, bus.y} < 11'(HEIGHT) && idx_d < MEM_END;
      rd_data_d = (ren_q && in_q) ? mem[bank_q][idx_q] : BORDER;
   end
   always_comb begin
      vb_rise = bus.vblank & ~vblank_q;
      state_d = state_q;
      front_sel_d = front_sel_q;
      cnt_d = cnt_q;
      fill_d = fill_q;
      case (state_q)
         IDLE:
            if (bus.clear_req) begin
               state_d = CLEAR;
               cnt_d = '0;
               fill_d = bus.clear_color;
            end else if (bus.swap_req) state_d = PENDING;
         PENDING:
            if (vb_rise) begin
               front_sel_d = ~front_sel_q;
`ifdef FB_AUTO_CLEAR_EN
               state_d = CLEAR;
               cnt_d = '0;
               fill_d = bus.clear_color;
`else
               state_d = IDLE;
`endif
            end
         CLEAR: begin
            cnt_d = cnt_q + ADDR_W'(1);
            state_d = (cnt_q == LAST) ? IDLE : CLEAR;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         front_sel_q <= 1'b0;
         vblank_q <= 1'b0;
         cnt_q <= '0;
         fill_q <= '0;
         idx_q <= '0;
         in_q <= 1'b0;
         ren_q <= 1'b0;
         bank_q <= 1'b0;
         rd_data_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         front_sel_q <= front_sel_d;
         vblank_q <= bus.vblank;
         cnt_q <= cnt_d;
         fill_q <= fill_d;
         idx_q <= idx_d[AW-1:0];
         in_q <= in_d;
         ren_q <= bus.rd_en;
         bank_q <= front_sel_q;
         rd_data_q <= rd_data_d;
         rd_valid_q <= ren_q;
      end
   end
   // CPU lanes and the fill engine are mutually exclusive; reset aborts the fill write in its cycle.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (lane_we[i]) mem[~front_sel_q][lane_a[i]] <= bus.wr_data[8*i +: 8];
      if (state_q == CLEAR && !rst) mem[~front_sel_q][cnt_q[AW-1:0]] <= fill_q;
   end
   assign bus.rd_data = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.front_sel = front_sel_q;
   assign bus.swap_pending = state_q == PENDING;
   assign bus.busy = state_q == CLEAR;
endmodule

// File: tb/tb_frame_buffer_db.sv
// tb_frame_buffer_db: scoreboard bench for frame_buffer_db at 8x4 resolution.
module tb_frame_buffer_db;
   localparam int W = 8, H = 4, MS = 32;
   typedef struct packed {logic [7:0] d; int c;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int errs = 0, checks = 0, cyc = 0;
   logic [7:0] mdl [2][MS];
   logic efront = 1'b0;
   exp_t sq[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   fb_if #(.ADDR_W(5)) bus ();
   frame_buffer_db #(.WIDTH(W), .HEIGHT(H), .ADDR_W(5), .BORDER(8'hFF)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   always @(negedge clk) begin
      if (bus.rd_valid === 1'b1) begin
         exp_t e;
         checks++;
         if (sq.size() == 0) begin
            errs++;
            $display("FAIL rd_unexpected: rd_valid=1 at cycle %0d, required no read outstanding", cyc);
         end else begin
            e = sq.pop_front();
            if (bus.rd_data !== e.d || cyc != e.c) begin
               errs++;
               $display("FAIL rd_data: got %h at cycle %0d, required %h at cycle %0d", bus.rd_data, cyc, e.d, e.c);
            end
         end
      end
   end
   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic fill_model(logic b, logic [7:0] c);
      for (int i = 0; i < MS; i++) mdl[b][i] = c;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         step();
         n++;
      end
      if (bus.busy !== 1'b0) begin
         checks++;
         errs++;
         $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
      end
   endtask
   task automatic swapped(logic [7:0] c);
      efront = ~efront;
`ifdef FB_AUTO_CLEAR_EN
      fill_model(~efront, c);
      wait_idle();
`else
      if (c === 8'hxx) efront = efront;
`endif
   endtask
   task automatic do_swap();
      bus.swap_req = 1'b1;
      step();
      bus.swap_req = 1'b0;
      bus.vblank = 1'b1;
      step();
      bus.vblank = 1'b0;
      swapped(bus.clear_color);
   endtask
   task automatic do_clear(logic [7:0] c);
      bus.clear_req = 1'b1;
      bus.clear_color = c;
      step();
      bus.clear_req = 1'b0;
      fill_model(~efront, c);
      wait_idle();
   endtask
   task automatic cpu_write(int a, logic [31:0] d, logic [3:0] m);
      bus.wr_en = 1'b1;
      bus.wr_addr = 5'(a);
      bus.wr_data = d;
      bus.wr_mask = m;
      step();
      bus.wr_en = 1'b0;
      bus.wr_mask = 4'h0;
      for (int i = 0; i < 4; i++)
         if (m[i] && a + i < MS) mdl[~efront][a+i] = d[8*i +: 8];
   endtask
   task automatic issue_read(int xx, int yy);
      exp_t e;
      bus.rd_en = 1'b1;
      bus.x = 10'(xx);
      bus.y = 10'(yy);
      e.d = (xx < W && yy < H) ? mdl[efront][(yy*W + xx) % MS] : 8'hFF;
      e.c = cyc + 2;
      sq.push_back(e);
      step();
      bus.rd_en = 1'b0;
   endtask
   task automatic read_all();
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++) issue_read(xx, yy);
      step(3);
   endtask
   task automatic test_reset();
      bus.swap_req = 1'b1;
      step();
      bus.swap_req = 1'b0;
      rst = 1'b1;
      step();
      checks++;
      if ({bus.rd_data, bus.rd_valid, bus.front_sel, bus.swap_pending, bus.busy} !== 12'h000) begin
         errs++;
         $display("FAIL reset_outputs: data/valid/front/pending/busy=%h/%b/%b/%b/%b, required 00/0/0/0/0",
                  bus.rd_data, bus.rd_valid, bus.front_sel, bus.swap_pending, bus.busy);
      end
      rst = 1'b0;
      efront = 1'b0;
      step();
      checks++;
      if (bus.rd_data !== 8'hFF) begin
         errs++;
         $display("FAIL idle_border: rd_data=%h, required ff", bus.rd_data);
      end
   endtask
   task automatic test_write_lanes();
      cpu_write(4, 32'hDDCCBBAA, 4'b0101);
      do_swap();
      issue_read(4, 0);
      issue_read(5, 0);
      issue_read(6, 0);
      issue_read(7, 0);
      step(3);
   endtask
   task automatic test_boundary();
      cpu_write(30, 32'h44332211, 4'hF);
      do_swap();
      issue_read(6, 3);
      issue_read(7, 3);
      issue_read(0, 0);
      issue_read(8, 0);
      issue_read(0, 4);
      issue_read(1023, 1023);
      step(3);
   endtask
   task automatic test_swap();
      logic f0;
      f0 = efront;
      bus.swap_req = 1'b1;
      step();
      bus.swap_req = 1'b0;
      checks++;
      if ({bus.swap_pending, bus.front_sel} !== {1'b1, f0}) begin
         errs++;
         $display("FAIL swap_arm: pending/front=%b/%b, required 1/%b", bus.swap_pending, bus.front_sel, f0);
      end
      bus.clear_req = 1'b1;
      step();
      bus.clear_req = 1'b0;
      step();
      checks++;
      if ({bus.swap_pending, bus.busy, bus.front_sel} !== {2'b10, f0}) begin
         errs++;
         $display("FAIL pending_hold: pending/busy/front=%b/%b/%b, required 1/0/%b", bus.swap_pending, bus.busy, bus.front_sel, f0);
      end
      bus.vblank = 1'b1;
      step();
      checks++;
      if ({bus.front_sel, bus.swap_pending} !== {~f0, 1'b0}) begin
         errs++;
         $display("FAIL swap_done: front/pending=%b/%b, required %b/0", bus.front_sel, bus.swap_pending, ~f0);
      end
      swapped(bus.clear_color);
      step(5);
      checks++;
      if (bus.front_sel !== efront) begin
         errs++;
         $display("FAIL vblank_hold: front=%b, required %b", bus.front_sel, efront);
      end
      bus.vblank = 1'b0;
      step();
      bus.swap_req = 1'b1;
      bus.vblank = 1'b1;
      step();
      bus.swap_req = 1'b0;
      step(3);
      checks++;
      if ({bus.swap_pending, bus.front_sel} !== {1'b1, efront}) begin
         errs++;
         $display("FAIL coincident_rise: pending/front=%b/%b, required 1/%b", bus.swap_pending, bus.front_sel, efront);
      end
      bus.vblank = 1'b0;
      step();
      bus.vblank = 1'b1;
      step();
      checks++;
      if ({bus.front_sel, bus.swap_pending} !== {~efront, 1'b0}) begin
         errs++;
         $display("FAIL next_rise: front/pending=%b/%b, required %b/0", bus.front_sel, bus.swap_pending, ~efront);
      end
      swapped(bus.clear_color);
      bus.vblank = 1'b0;
      step();
   endtask
   task automatic test_clear();
      int n = 0;
      bus.clear_req = 1'b1;
      bus.clear_color = 8'h3C;
      step();
      bus.clear_req = 1'b0;
      bus.clear_color = 8'h99;
      while (bus.busy === 1'b1 && n < 100) begin
         if (n == 5) begin
            bus.wr_en = 1'b1;
            bus.wr_addr = 5'd0;
            bus.wr_data = 32'h12345678;
            bus.wr_mask = 4'hF;
         end
         bus.swap_req = (n == 7);
         step();
         bus.wr_en = 1'b0;
         bus.wr_mask = 4'h0;
         bus.swap_req = 1'b0;
         n++;
      end
      checks++;
      if (n != 32 || bus.swap_pending !== 1'b0) begin
         errs++;
         $display("FAIL clear_len: busy cycles=%0d pending=%b, required 32/0", n, bus.swap_pending);
      end
      fill_model(~efront, 8'h3C);
      do_swap();
      read_all();
   endtask
   task automatic test_clear_swap_reset();
      logic ob;
      ob = ~efront;
      bus.clear_req = 1'b1;
      bus.swap_req = 1'b1;
      bus.clear_color = 8'hC3;
      step();
      bus.clear_req = 1'b0;
      bus.swap_req = 1'b0;
      checks++;
      if ({bus.busy, bus.swap_pending} !== 2'b10) begin
         errs++;
         $display("FAIL clear_priority: busy/pending=%b/%b, required 1/0", bus.busy, bus.swap_pending);
      end
      step(10);
      rst = 1'b1;
      step();
      checks++;
      if ({bus.busy, bus.front_sel} !== 2'b00) begin
         errs++;
         $display("FAIL clear_abort: busy/front=%b/%b, required 0/0", bus.busy, bus.front_sel);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) mdl[ob][i] = 8'hC3;
      efront = 1'b0;
      if (efront != ob) do_swap();
      read_all();
   endtask
   task automatic test_auto_clear();
      int n = 0;
      bus.clear_color = 8'h77;
      bus.swap_req = 1'b1;
      step();
      bus.swap_req = 1'b0;
      bus.vblank = 1'b1;
      step();
      bus.vblank = 1'b0;
      efront = ~efront;
      checks++;
      if (bus.front_sel !== efront) begin
         errs++;
         $display("FAIL auto_swap: front=%b, required %b", bus.front_sel, efront);
      end
`ifdef FB_AUTO_CLEAR_EN
      while (bus.busy === 1'b1 && n < 100) begin
         step();
         n++;
      end
      checks++;
      if (n != 32) begin
         errs++;
         $display("FAIL auto_clear_len: busy cycles=%0d, required 32", n);
      end
      fill_model(~efront, 8'h77);
`else
      step(3);
      n = bus.busy ? 1 : 0;
      checks++;
      if (n != 0) begin
         errs++;
         $display("FAIL no_auto_clear: busy=%0d, required 0", n);
      end
`endif
      bus.clear_color = 8'h00;
      do_swap();
      read_all();
   endtask
   initial begin
      bus.wr_en = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.wr_mask = '0;
      bus.rd_en = 1'b0;
      bus.x = '0;
      bus.y = '0;
      bus.vblank = 1'b0;
      bus.swap_req = 1'b0;
      bus.clear_req = 1'b0;
      bus.clear_color = '0;
      step(2);
      rst = 1'b0;
      do_clear(8'h5A);
      do_swap();
      do_clear(8'hA5);
      test_reset();
      test_write_lanes();
      test_boundary();
      test_swap();
      test_clear();
      test_clear_swap_reset();
      test_auto_clear();
      step(4);
      checks++;
      if (sq.size() != 0) begin
         errs++;
         $display("FAIL reads_outstanding: %0d reads never returned, required 0", sq.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
